// File: rtl/c_bus_reg_bank_pkg.sv
// c_bus_reg_bank_pkg: shared B/C-bus register code space and datapath widths
package c_bus_reg_bank_pkg;

   localparam int DW_DEF  = 32;
   localparam int PCW_DEF = 6;

   typedef enum logic [4:0] {
      SEL_NONE = 5'b00000,
      SEL_MDR  = 5'b00001,
      SEL_K0   = 5'b00010,
      SEL_K1   = 5'b00011,
      SEL_K2   = 5'b00100,
      SEL_K3   = 5'b00101,
      SEL_K4   = 5'b00110,
      SEL_K5   = 5'b00111,
      SEL_K6   = 5'b01000,
      SEL_K7   = 5'b01001,
      SEL_K8   = 5'b01010,
      SEL_P1   = 5'b01011,
      SEL_P2   = 5'b01100,
      SEL_P3   = 5'b01101,
      SEL_DP   = 5'b01110,
      SEL_CV   = 5'b01111,
      SEL_I    = 5'b10000,
      SEL_MBRU = 5'b10001,
      SEL_AC   = 5'b10010,
      SEL_PC   = 5'b10011,
      SEL_MAR  = 5'b10111
   } sel_e;

   // Physical slot of each writable register in the bank; PC is last and kept apart
   // because it is the only register narrower than DW.
   localparam int R_MDR = 0;
   localparam int R_K0  = 1;
   localparam int R_P1  = 10;
   localparam int R_P2  = 11;
   localparam int R_P3  = 12;
   localparam int R_DP  = 13;
   localparam int R_CV  = 14;
   localparam int R_I   = 15;
   localparam int R_MAR = 16;
   localparam int R_AC  = 17;
   localparam int R_PC  = 18;
   localparam int NREG  = 19;

endpackage

// File: rtl/c_bus_dest_decoder.sv
// c_bus_dest_decoder: C-bus destination code to one-hot write enables plus illegal flag
module c_bus_dest_decoder
   import c_bus_reg_bank_pkg::*;
(
   input  logic [4:0]      sel,
   input  logic            wr,
   output logic [NREG-1:0] we,
   output logic            illegal
);

   logic [NREG-1:0] dec;
   logic            legal;

   // Map each writable code to its bank slot; unlisted codes (incl. read-only MBRU) decode to nothing
   always_comb begin
      dec = '0;
      case (sel)
         SEL_MDR: dec[R_MDR]    = 1'b1;
         SEL_K0:  dec[R_K0 + 0] = 1'b1;
         SEL_K1:  dec[R_K0 + 1] = 1'b1;
         SEL_K2:  dec[R_K0 + 2] = 1'b1;
         SEL_K3:  dec[R_K0 + 3] = 1'b1;
         SEL_K4:  dec[R_K0 + 4] = 1'b1;
         SEL_K5:  dec[R_K0 + 5] = 1'b1;
         SEL_K6:  dec[R_K0 + 6] = 1'b1;
         SEL_K7:  dec[R_K0 + 7] = 1'b1;
         SEL_K8:  dec[R_K0 + 8] = 1'b1;
         SEL_P1:  dec[R_P1]     = 1'b1;
         SEL_P2:  dec[R_P2]     = 1'b1;
         SEL_P3:  dec[R_P3]     = 1'b1;
         SEL_DP:  dec[R_DP]     = 1'b1;
         SEL_CV:  dec[R_CV]     = 1'b1;
         SEL_I:   dec[R_I]      = 1'b1;
         SEL_AC:  dec[R_AC]     = 1'b1;
         SEL_PC:  dec[R_PC]     = 1'b1;
         SEL_MAR: dec[R_MAR]    = 1'b1;
         default: ;
      endcase
   end

   assign legal   = |dec;
   assign we      = wr ? dec : '0;
   assign illegal = wr & ~legal;

endmodule

// File: rtl/c_bus_reg_bank.sv
// c_bus_reg_bank: C-bus write-back register bank with PC/I/DP increment and MDR load
module c_bus_reg_bank
   import c_bus_reg_bank_pkg::*;
#(
   parameter int DW  = DW_DEF,
   parameter int PCW = PCW_DEF
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [4:0]     C_sel,
   input  logic           C_wr,
   input  logic [DW-1:0]  C_Bus,
   input  logic           pc_inc,
   input  logic           i_inc,
   input  logic           dp_inc,
   input  logic           mem_load,
   input  logic [DW-1:0]  mem_data,
   output logic [DW-1:0]  AC,
   output logic [DW-1:0]  MAR,
   output logic [DW-1:0]  MDR,
   output logic [PCW-1:0] PC,
   output logic [DW-1:0]  K0,
   output logic [DW-1:0]  K1,
   output logic [DW-1:0]  K2,
   output logic [DW-1:0]  K3,
   output logic [DW-1:0]  K4,
   output logic [DW-1:0]  K5,
   output logic [DW-1:0]  K6,
   output logic [DW-1:0]  K7,
   output logic [DW-1:0]  K8,
   output logic [DW-1:0]  P1,
   output logic [DW-1:0]  P2,
   output logic [DW-1:0]  P3,
   output logic [DW-1:0]  DP,
   output logic [DW-1:0]  CV,
   output logic [DW-1:0]  I,
   output logic           sel_err
);

   logic [NREG-1:0] we;
   logic            illegal;
   logic [DW-1:0]   r [R_PC];
   logic [PCW-1:0]  pc;

   c_bus_dest_decoder u_dec (
      .sel     (C_sel),
      .wr      (C_wr),
      .we      (we),
      .illegal (illegal)
   );

   // Bank update: C-bus writes first, then later assignments override (mem_load over MDR write,
   // increments only where no write hit); reset clears everything regardless of strobes
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < R_PC; k++) r[k] <= '0;
         pc      <= '0;
         sel_err <= 1'b0;
      end else begin
         for (int k = 0; k < R_PC; k++) if (we[k]) r[k] <= C_Bus;
         if (mem_load) r[R_MDR] <= mem_data;
         if (i_inc && !we[R_I]) r[R_I] <= r[R_I] + DW'(1);
         if (dp_inc && !we[R_DP]) r[R_DP] <= r[R_DP] + DW'(1);
         pc      <= we[R_PC] ? C_Bus[PCW-1:0] : pc_inc ? pc + PCW'(1) : pc;
         sel_err <= sel_err | illegal;
      end
   end

   assign MDR = r[R_MDR];
   assign K0  = r[R_K0 + 0];
   assign K1  = r[R_K0 + 1];
   assign K2  = r[R_K0 + 2];
   assign K3  = r[R_K0 + 3];
   assign K4  = r[R_K0 + 4];
   assign K5  = r[R_K0 + 5];
   assign K6  = r[R_K0 + 6];
   assign K7  = r[R_K0 + 7];
   assign K8  = r[R_K0 + 8];
   assign P1  = r[R_P1];
   assign P2  = r[R_P2];
   assign P3  = r[R_P3];
   assign DP  = r[R_DP];
   assign CV  = r[R_CV];
   assign I   = r[R_I];
   assign MAR = r[R_MAR];
   assign AC  = r[R_AC];
   assign PC  = pc;

endmodule

// File: tb/tb_c_bus_reg_bank.sv
// tb_c_bus_reg_bank: directed self-checking bench for the C-bus register bank
module tb_c_bus_reg_bank;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  C_sel = '0;
   logic        C_wr = 1'b0;
   logic [31:0] C_Bus = '0;
   logic        pc_inc = 1'b0, i_inc = 1'b0, dp_inc = 1'b0, mem_load = 1'b0;
   logic [31:0] mem_data = '0;
   logic [31:0] AC, MAR, MDR, K0, K1, K2, K3, K4, K5, K6, K7, K8, P1, P2, P3, DP, CV, I;
   logic [5:0]  PC;
   logic        sel_err;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] exp_r [32];
   logic        exp_err;
   logic [4:0]  legal_codes [19] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
                                     5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd18, 5'd19, 5'd23};

   c_bus_reg_bank dut (
      .clk(clk), .rst(rst), .C_sel(C_sel), .C_wr(C_wr), .C_Bus(C_Bus),
      .pc_inc(pc_inc), .i_inc(i_inc), .dp_inc(dp_inc), .mem_load(mem_load), .mem_data(mem_data),
      .AC(AC), .MAR(MAR), .MDR(MDR), .PC(PC),
      .K0(K0), .K1(K1), .K2(K2), .K3(K3), .K4(K4), .K5(K5), .K6(K6), .K7(K7), .K8(K8),
      .P1(P1), .P2(P2), .P3(P3), .DP(DP), .CV(CV), .I(I), .sel_err(sel_err)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] obs(input logic [4:0] c);
      case (c)
         5'd1:  return MDR;
         5'd2:  return K0;
         5'd3:  return K1;
         5'd4:  return K2;
         5'd5:  return K3;
         5'd6:  return K4;
         5'd7:  return K5;
         5'd8:  return K6;
         5'd9:  return K7;
         5'd10: return K8;
         5'd11: return P1;
         5'd12: return P2;
         5'd13: return P3;
         5'd14: return DP;
         5'd15: return CV;
         5'd16: return I;
         5'd18: return AC;
         5'd19: return {26'b0, PC};
         5'd23: return MAR;
         default: return 32'hXXXXXXXX;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      n_cmp++;
      assert (o === e) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, o, e);
      end
   endtask

   task automatic check_all(input string step);
      for (int k = 0; k < 19; k++)
         chk($sformatf("%s reg%0d", step, legal_codes[k]), obs(legal_codes[k]), exp_r[legal_codes[k]]);
      chk($sformatf("%s sel_err", step), {31'b0, sel_err}, {31'b0, exp_err});
   endtask

   task automatic clear_exp();
      for (int k = 0; k < 32; k++) exp_r[k] = '0;
      exp_err = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [4:0] c, input logic [31:0] d);
      C_wr = 1'b1;
      C_sel = c;
      C_Bus = d;
      tick();
      C_wr = 1'b0;
   endtask

   initial begin
      clear_exp();
      // 1: dirty the bank, reset for two cycles, then a single CV write
      tick();
      rst = 1'b0;
      wr(5'd18, $urandom);
      wr(5'd6, $urandom);
      wr(5'd19, $urandom);
      wr(5'd17, 32'h1);
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check_all("reset");
      wr(5'd15, 32'hDEADBEEF);
      exp_r[15] = 32'hDEADBEEF;
      check_all("cv_write");

      // 2: sweep every legal code with a code-tagged value
      for (int k = 0; k < 19; k++) begin
         wr(legal_codes[k], {27'b0, legal_codes[k]} * 32'h01010101);
         exp_r[legal_codes[k]] = (legal_codes[k] == 5'd19) ? {26'b0, 6'h13} : {27'b0, legal_codes[k]} * 32'h01010101;
         check_all($sformatf("sweep%0d", legal_codes[k]));
      end
      wr(5'd19, 32'hFFFFFFC5);
      exp_r[19] = 32'h5;
      check_all("pc_trunc");

      // 3: wraparound and write-beats-increment
      wr(5'd19, 32'd63);
      exp_r[19] = 32'd63;
      pc_inc = 1'b1;
      tick();
      pc_inc = 1'b0;
      exp_r[19] = 32'd0;
      check_all("pc_wrap");
      wr(5'd16, 32'hFFFFFFFF);
      i_inc = 1'b1;
      tick();
      i_inc = 1'b0;
      exp_r[16] = 32'd0;
      check_all("i_wrap");
      dp_inc = 1'b1;
      wr(5'd14, 32'h10);
      dp_inc = 1'b0;
      exp_r[14] = 32'h10;
      check_all("dp_wr_beats_inc");
      dp_inc = 1'b1;
      tick();
      dp_inc = 1'b0;
      exp_r[14] = 32'h11;
      check_all("dp_inc");

      // 4: mem_load beats a C-bus write to MDR
      mem_load = 1'b1;
      mem_data = 32'hA5A5A5A5;
      wr(5'd1, 32'h12345678);
      mem_load = 1'b0;
      exp_r[1] = 32'hA5A5A5A5;
      check_all("mdr_prio");

      // all five independent updates in one cycle
      pc_inc = 1'b1; i_inc = 1'b1; dp_inc = 1'b1; mem_load = 1'b1; mem_data = 32'h0BADF00D;
      wr(5'd5, 32'hCAFEF00D);
      pc_inc = 1'b0; i_inc = 1'b0; dp_inc = 1'b0; mem_load = 1'b0;
      exp_r[5] = 32'hCAFEF00D;
      exp_r[19] = 32'd1;
      exp_r[16] = 32'd1;
      exp_r[14] = 32'h12;
      exp_r[1] = 32'h0BADF00D;
      check_all("parallel");

      // C_wr low with an illegal code does nothing
      C_sel = 5'd31;
      C_Bus = 32'hFFFFFFFF;
      tick();
      check_all("no_wr");

      // 5: illegal write is sticky, changes nothing
      wr(5'd17, 32'hFFFFFFFF);
      exp_err = 1'b1;
      check_all("illegal");
      for (int k = 0; k < 10; k++) begin
         wr(legal_codes[k], 32'h100 + k);
         exp_r[legal_codes[k]] = 32'h100 + k;
         check_all($sformatf("sticky%0d", k));
      end
      wr(5'd0, 32'h77);
      check_all("illegal_zero");
      wr(5'd25, 32'h77);
      check_all("illegal_high");
      rst = 1'b1;
      tick();
      rst = 1'b0;
      clear_exp();
      check_all("err_clear");
      wr(5'd21, 32'h77);
      exp_err = 1'b1;
      check_all("illegal_10101");
      rst = 1'b1;
      tick();
      rst = 1'b0;
      clear_exp();

      // 6: reset overrides a concurrent write and increment
      wr(5'd19, 32'd7);
      wr(5'd18, 32'd9);
      exp_r[19] = 32'd7;
      exp_r[18] = 32'd9;
      check_all("pre_rst");
      rst = 1'b1;
      pc_inc = 1'b1;
      wr(5'd18, 32'h55);
      rst = 1'b0;
      pc_inc = 1'b0;
      clear_exp();
      check_all("rst_prio");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
